// File: rtl/xor_stream_descrambler.sv
// Additive Galois-LFSR stream descrambler, one registered valid/ready stage.
// Optional accepted-word counter enabled by `XOR_DESCR_WORD_COUNT_EN.
module xor_stream_descrambler #(
  parameter int N = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N-1:0]      s_data,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef XOR_DESCR_WORD_COUNT_EN
  output logic [31:0]       word_count,
`endif
  output logic [N-1:0]      m_data
);

  logic [LFSR_W-1:0] lfsr, lfsr_nxt, st;
  logic [N-1:0]      key;
  logic              accept;

  // Keystream bit i is bit 0 of the state after i steps; state advances N steps per word.
  always_comb begin
    st  = lfsr;
    key = '0;
    for (int i = 0; i < N; i++) begin
      key[i] = st[0];
      st     = (st >> 1) ^ (st[0] ? TAPS : '0);
    end
    lfsr_nxt = st;
  end

  assign s_ready = !seed_load && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_W'(1);
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (seed_load) begin
      // An all-zero state would never leave zero, so map it to 1.
      lfsr    <= (seed == '0) ? LFSR_W'(1) : seed;
      m_valid <= 1'b0;
    end else if (accept) begin
      m_data  <= s_data ^ key;
      m_valid <= 1'b1;
      lfsr    <= lfsr_nxt;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef XOR_DESCR_WORD_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_count <= '0;
    else if (seed_load)
      word_count <= '0;
    else if (accept && (word_count != 32'hFFFF_FFFF))
      word_count <= word_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed + loopback bench for xor_stream_descrambler.
module tb_xor_stream_descrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
`ifdef XOR_DESCR_WORD_COUNT_EN
  logic [31:0] word_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  xor_stream_descrambler #(.N(8), .LFSR_W(16), .TAPS(16'hB400)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
`ifdef XOR_DESCR_WORD_COUNT_EN
    .word_count(word_count),
`endif
    .m_data(m_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transmit-side scrambler: returns key word and advances the state 8 steps.
  task automatic tx_key(inout logic [15:0] st, output logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      k[i] = st[0];
      st   = (st >> 1) ^ (st[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic load_seed(input logic [15:0] v);
    seed_load = 1'b1; seed = v; s_valid = 1'b0;
    step();
    seed_load = 1'b0;
  endtask

  logic [15:0] tx_st;
  logic [7:0]  k, plain, pend_plain, pend_data;
  logic        pending;
  logic [7:0]  expq[$];
  int          sent, recv, cyc;

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) step();
    // 1: reset
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef XOR_DESCR_WORD_COUNT_EN
    chk("rst_count", word_count, 32'd0);
`endif

    // 2: known keys 01, 68 from seed 1
    seed_load = 1'b1; seed = 16'h0001; #1;
    chk("seed_s_ready", 32'(s_ready), 32'd0);
    step();
    seed_load = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    step();
    chk("t2_valid1", 32'(m_valid), 32'd1);
    chk("t2_data1",  32'(m_data),  32'hA4);
    step();
    chk("t2_data2",  32'(m_data),  32'hCD);
    s_valid = 1'b0;
    step();
    chk("t2_drain",  32'(m_valid), 32'd0);

    // 3: backpressure holds data and freezes the keystream
    load_seed(16'h0001);
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
    step();
    chk("t3_data1", 32'(m_data), 32'hA4);
    chk("t3_sready_bp", 32'(s_ready), 32'd0);
    step(); step();
    chk("t3_hold_valid", 32'(m_valid), 32'd1);
    chk("t3_hold_data",  32'(m_data),  32'hA4);
    m_ready = 1'b1; #1;
    chk("t3_sready_rel", 32'(s_ready), 32'd1);
    step();
    chk("t3_data2", 32'(m_data), 32'hCD);
    step();
    chk("t3_data3", 32'(m_data), 32'hE4);
    s_valid = 1'b0;
    step();
    chk("t3_drain", 32'(m_valid), 32'd0);

    // 4: zero seed behaves like seed 1
    load_seed(16'h0000);
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    chk("t4_data1", 32'(m_data), 32'hA4);
    step();
    chk("t4_data2", 32'(m_data), 32'hCD);
    s_valid = 1'b0;
    step();

    // 5: seed_load drops in-flight word and blocks accept
    load_seed(16'h0001);
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    chk("t5_pre_valid", 32'(m_valid), 32'd1);
    seed_load = 1'b1; seed = 16'h0001; #1;
    chk("t5_sready", 32'(s_ready), 32'd0);
    step();
    chk("t5_dropped", 32'(m_valid), 32'd0);
`ifdef XOR_DESCR_WORD_COUNT_EN
    chk("t5_count_clr", word_count, 32'd0);
`endif
    seed_load = 1'b0;
    step();
    chk("t5_newkey", 32'(m_data), 32'hA4);
    s_valid = 1'b0;

    // reset mid-stream clears state immediately and restores lfsr=1
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b0;
    step();
    chk("rst2_pre", 32'(m_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst2_valid", 32'(m_valid), 32'd0);
    chk("rst2_data",  32'(m_data),  32'd0);
    step();
    rst_n = 1'b1; m_ready = 1'b1; s_data = 8'hA5;
    step();
    chk("rst2_lfsr1", 32'(m_data), 32'hA4);
    s_valid = 1'b0;
    step();

    // 6: loopback against transmit scrambler with random valid/ready
    load_seed(16'hACE1);
    tx_st = 16'hACE1; pending = 1'b0; sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      if (!pending && sent < 1000 && ($urandom_range(3) != 0)) begin
        plain = 8'($urandom);
        tx_key(tx_st, k);
        pend_plain = plain; pend_data = plain ^ k; pending = 1'b1;
      end
      s_valid = pending; s_data = pend_data;
      m_ready = ($urandom_range(3) != 0);
      #1;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("lb_underflow", 32'd1, 32'd0);
        else chk("lb_data", 32'(m_data), 32'(expq.pop_front()));
        recv++;
      end
      if (s_valid && s_ready) begin
        expq.push_back(pend_plain);
        pending = 1'b0;
        sent++;
      end
      step();
      cyc++;
    end
    chk("lb_received", 32'(recv), 32'd1000);
`ifdef XOR_DESCR_WORD_COUNT_EN
    chk("lb_count", word_count, 32'd1000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
